// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RV32I controller and ALU
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp and instruction fields to the ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Only R-type (op5=1) with funct7b5 set turns funct3=000 into a subtract;
  // addi with imm[10]=1 must still add.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM and immediate/ALU decode for the multicycle core
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [2:0] ALUControl
);

  state_t     state;
  state_t     state_next;
  state_t     cur;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;

  // State register; reset may land mid-instruction and always restarts at fetch
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore output decode; while reset is held the selects already look like FETCH
  always_comb begin
    cur       = reset ? S_FETCH : state;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    alu_op    = ALUOP_ADD;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_REG;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_REG;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: begin
        ir_write = 1'b0;
      end
    endcase
  end

  // Strobes are suppressed for the whole reset window so nothing commits mid-reset
  always_comb begin
    IRWrite  = ir_write & ~reset;
    PCWrite  = (pc_update | (branch & zero)) & ~reset;
    RegWrite = reg_write & ~reset;
    MemWrite = mem_write & ~reset;
  end

  // Immediate format follows the opcode directly, independent of state
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for the multicycle controller
module tb_multicycle_controller;

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_J, P_B} phase_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic [2:0] ALUControl;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUControl(ALUControl)
  );

  // Number of cycles each instruction class occupies, FETCH included
  function automatic int instr_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 2;
    endcase
  endfunction

  // Which step of the instruction walk cycle i falls on
  function automatic phase_t phase_at(input logic [6:0] o, input int i);
    if (i == 0) return P_F;
    if (i == 1) return P_D;
    case (o)
      7'b0000011: return (i == 2) ? P_MA : (i == 3) ? P_MR : P_MWB;
      7'b0100011: return (i == 2) ? P_MA : P_MW;
      7'b0110011: return (i == 2) ? P_ER : P_AWB;
      7'b0010011: return (i == 2) ? P_EI : P_AWB;
      7'b1101111: return (i == 2) ? P_J : P_AWB;
      default:    return P_B;
    endcase
  endfunction

  // ALU operation the instruction asks for, given the ALUOp class of the step
  function automatic logic [2:0] alu_ref(input int aluop, input logic [2:0] f3, input logic op5, input logic f7);
    if (aluop == 1) return 3'b001;
    if (aluop != 2) return 3'b000;
    if (f3 == 3'b000) return (op5 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [15:0] expect_out(input phase_t ph, input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7, input logic z, input logic rst);
    logic [1:0] imm, sa, sb, rs;
    logic adr, irw, pcu, br, rw, mw, pcw;
    int aluop;
    phase_t p;
    p = rst ? P_F : ph;
    sa = 0; sb = 0; rs = 0; adr = 0; irw = 0; pcu = 0; br = 0; rw = 0; mw = 0; aluop = 0;
    case (p)
      P_F:   begin irw = 1; sb = 2; rs = 2; pcu = 1; end
      P_D:   begin sa = 1; sb = 1; end
      P_MA:  begin sa = 2; sb = 1; end
      P_MR:  begin adr = 1; end
      P_MWB: begin rs = 1; rw = 1; end
      P_MW:  begin adr = 1; mw = 1; end
      P_ER:  begin sa = 2; aluop = 2; end
      P_EI:  begin sa = 2; sb = 1; aluop = 2; end
      P_AWB: begin rw = 1; end
      P_J:   begin sa = 1; sb = 2; pcu = 1; end
      P_B:   begin sa = 2; aluop = 1; br = 1; end
      default: ;
    endcase
    imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
    pcw = pcu | (br & z);
    if (rst) begin irw = 0; pcw = 0; rw = 0; mw = 0; end
    return {imm, sa, sb, rs, adr, irw, pcw, rw, mw, alu_ref(aluop, f3, o[5], f7)};
  endfunction

  task automatic check(input string tag, input phase_t ph);
    logic [15:0] obs, exp;
    obs = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUControl};
    exp = expect_out(ph, op, funct3, funct7b5, zero, reset);
    check_count++;
    assert (obs === exp) begin
      pass_count++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction from FETCH to its last cycle; zm < 0 means random zero each cycle
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zm);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < instr_len(o); i++) begin
      zero = (zm < 0) ? 1'($urandom_range(0, 1)) : 1'(zm);
      #1;
      check($sformatf("%s_c%0d", name, i + 1), phase_at(o, i));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [6:0] legal [6];
    logic [6:0] o;
    legal[0] = 7'b0000011; legal[1] = 7'b0100011; legal[2] = 7'b0110011;
    legal[3] = 7'b0010011; legal[4] = 7'b1101111; legal[5] = 7'b1100011;

    reset = 1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 0; zero = 1;
    @(posedge clk); #1;
    check("reset_a", P_F);
    @(posedge clk); #1;
    check("reset_b", P_F);
    reset = 0;

    // lw interrupted by a two-cycle reset during MEMADR
    #1; check("midrst_fetch", P_F);
    @(posedge clk); #1; check("midrst_decode", P_D);
    @(posedge clk); #1; check("midrst_memadr", P_MA);
    reset = 1; #1; check("midrst_hold1", P_MA);
    @(posedge clk); #1; check("midrst_hold2", P_MA);
    @(posedge clk); #1;
    reset = 0;

    run_instr("lw",    7'b0000011, 3'b010, 1'b0, -1);
    run_instr("sw",    7'b0100011, 3'b010, 1'b0, -1);
    run_instr("sub",   7'b0110011, 3'b000, 1'b1, -1);
    run_instr("add",   7'b0110011, 3'b000, 1'b0, -1);
    run_instr("addi",  7'b0010011, 3'b000, 1'b1, -1);
    run_instr("slt",   7'b0110011, 3'b010, 1'b0, -1);
    run_instr("or",    7'b0110011, 3'b110, 1'b0, -1);
    run_instr("and",   7'b0110011, 3'b111, 1'b0, -1);
    run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1);
    run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 0);
    run_instr("jal",   7'b1101111, 3'b101, 1'b1, -1);
    run_instr("ill",   7'b0000000, 3'b000, 1'b0, 1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) o = 7'($urandom);
      else o = legal[$urandom_range(0, 5)];
      run_instr($sformatf("rnd%0d", n), o, 3'($urandom), 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM plus ALU decoder for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). It consumes the instruction register fields and the ALU Zero flag. It produces datapath mux selects, register/memory write strobes and the 3-bit ALUControl that drives the ALU. It sits directly upstream of the ALU and closes the branch loop through Zero.

Parameters:
none (encodings are fixed by the ISA subset and the ALU; see Decomposition)

Ports:
clk  in  1  core clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU Zero flag, sampled combinationally in BEQ
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUSrcA  out  2  00 PC, 01 OldPC, 10 register A
ALUSrcB  out  2  00 register B, 01 ImmExt, 10 constant 4
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
AdrSrc  out  1  0 PC, 1 Result (memory address mux)
IRWrite  out  1  load instruction register and OldPC
PCWrite  out  1  load PC from Result
RegWrite  out  1  register file write enable
MemWrite  out  1  data memory write enable
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt

Behaviour:
- Moore FSM, one state register; all select and strobe outputs decode from state only. Exception: PCWrite = PCUpdate | (Branch & zero).
- States and outputs (unlisted selects = 00/0, unlisted strobes = 0):
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1 -> DECODE
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH (illegal op is a no-op; no strobes fire)
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00 -> MEMREAD if op=0000011, else MEMWRITE
  - MEMREAD: ResultSrc 00, AdrSrc 1 -> MEMWB
  - MEMWB: ResultSrc 01, RegWrite 1 -> FETCH
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1 -> FETCH
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10 -> ALUWB
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10 -> ALUWB
  - ALUWB: ResultSrc 00, RegWrite 1 -> FETCH
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 -> ALUWB
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1 -> FETCH
- Instruction latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
- ALU decoder (combinational):
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 by funct3: 000 -> 001 if {op[5],funct7b5}=11, else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
  - ALUOp 11 -> 000.
- ImmSrc from op (combinational): 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all other ops -> 00.
- Reset: on any clk edge with reset=1, state <= FETCH, including mid-instruction. While reset=1, IRWrite, PCWrite, RegWrite and MemWrite are forced 0; selects show FETCH values. First fetch occurs in the cycle after reset deasserts.
- zero is ignored in every state except BEQ. An X on op outside DECODE/MEMADR must not affect state.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALUOp codes
  - ALUControl codes, shared with the ALU
  - mux-select codes for ALUSrcA, ALUSrcB, ResultSrc and ImmSrc
- Sub-module alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl), purely combinational. The FSM and instruction decoder stay in multicycle_controller.

Test Plan:
- Reset mid-instruction: hold reset 2 cycles during MEMADR of lw -> state FETCH, all four strobes 0 during reset; IRWrite=1 in first cycle after release.
- lw (op 0000011, f3 010) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; ImmSrc=00.
- sub (op 0110011, f3 000, f7b5 1) -> EXECUTER shows ALUControl 001. Same with op 0010011 (addi, f7b5 1) -> 000. slt f3 010 -> 101; or -> 011; and -> 010.
- beq (op 1100011) with zero=1 -> PCWrite=1 in cycle 3 with ALUControl 001. With zero=0 -> PCWrite=0; next state FETCH.
- jal (op 1101111) -> PCWrite=1 in JAL cycle, RegWrite=1 in the following ALUWB cycle, ImmSrc=11.
- Illegal op 0000000 -> FETCH, DECODE, FETCH; RegWrite, MemWrite and PCWrite stay 0 after the FETCH cycle.
